// File: rtl/gate_ex_pkg.sv
// Shared types, opcode encodings and truth tables
// for the two-input gate exerciser.
package gate_ex_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam logic [1:0] OP_OR   = 2'd0;
  localparam logic [1:0] OP_AND  = 2'd1;
  localparam logic [1:0] OP_NAND = 2'd2;
  localparam logic [1:0] OP_NOR  = 2'd3;

  // bit i holds the output for {a,b} = i
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  function automatic logic expected(
    input logic [1:0] op,
    input logic       a,
    input logic       b
  );
    logic [3:0] tt;
    tt = TT_OR;
    unique case (op)
      OP_OR:   tt = TT_OR;
      OP_AND:  tt = TT_AND;
      OP_NAND: tt = TT_NAND;
      OP_NOR:  tt = TT_NOR;
    endcase
    return tt[{a, b}];
  endfunction

endpackage

// File: rtl/gate_exerciser_settle_timer.sv
// 4-bit loadable down-counter with a zero flag,
// used to time the settle window.
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] val_i,
  input  logic       en_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/gate_exerciser.sv
// Drives a/b of a gate under test, samples c after a
// settle window and accumulates mismatch results.
module gate_exerciser
  import gate_ex_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned NUM_PASSES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       c,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] SETTLE_LD =
    (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
  localparam logic [5:0] PASS_LAST =
    6'(NUM_PASSES - 1);

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] idx_q, idx_d;
  logic [5:0] pcnt_q, pcnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic [7:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic       tmr_ld, tmr_en, tmr_zero;

  settle_timer u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_ld),
    .val_i  (SETTLE_LD),
    .en_i   (tmr_en),
    .zero_o (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      idx_q   <= 2'd0;
      pcnt_q  <= 6'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= 8'd0;
      fail_q  <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      pcnt_q  <= pcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    pcnt_d  = pcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    tmr_ld  = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          err_d   = 8'd0;
          fail_d  = 4'd0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          pcnt_d  = 6'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        tmr_ld  = 1'b1;
        state_d = (SETTLE_CYC == 0) ? S_SAMPLE
                                    : S_SETTLE;
      end
      S_SETTLE: begin
        if (tmr_zero) begin
          state_d = S_SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_SAMPLE: begin
        if (c != expected(op_q, a_q, b_q)) begin
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
          fail_d[idx_q] = 1'b1;
        end
        if (idx_q == 2'd3 && pcnt_q == PASS_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            pcnt_d = pcnt_q + 6'd1;
          end
          a_d     = idx_d[1];
          b_d     = idx_d[0];
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        // err_q already includes the final sample here
        pass_d  = (err_q == 8'd0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Scoreboard bench for gate_exerciser: three instances
// cover default, multi-pass and zero-settle configurations.
module tb_gate_exerciser;

  typedef struct {
    int id;
    int err;
    int fv;
    int ps;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] op = 2'd0;
  logic       start_w [3];
  logic       c_w     [3];
  logic       a_w     [3];
  logic       b_w     [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       pass_w  [3];
  logic [7:0] err_w   [3];
  logic [3:0] fail_w  [3];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sbq[$];

  logic gsel = 1'b0;
  logic glitch_en = 1'b0;
  int   pos0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign c_w[0] = (gsel ? (a_w[0] & b_w[0])
                        : (a_w[0] | b_w[0]))
                ^ (glitch_en & busy_w[0] & (pos0 != 3));
  assign c_w[1] = 1'b1;
  assign c_w[2] = ~(a_w[2] | b_w[2]);

  gate_exerciser u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]),
    .op(op), .c(c_w[0]), .a(a_w[0]), .b(b_w[0]),
    .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .err_count(err_w[0]),
    .fail_vec(fail_w[0])
  );

  gate_exerciser #(.SETTLE_CYC(2), .NUM_PASSES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]),
    .op(op), .c(c_w[1]), .a(a_w[1]), .b(b_w[1]),
    .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .err_count(err_w[1]),
    .fail_vec(fail_w[1])
  );

  gate_exerciser #(.SETTLE_CYC(0), .NUM_PASSES(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]),
    .op(op), .c(c_w[2]), .a(a_w[2]), .b(b_w[2]),
    .busy(busy_w[2]), .done(done_w[2]),
    .pass(pass_w[2]), .err_count(err_w[2]),
    .fail_vec(fail_w[2])
  );

  task automatic chk(input string nm, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, req);
    end
  endtask

  // monitor
  logic pbusy [3] = '{1'b0, 1'b0, 1'b0};
  int   acc   [3] = '{0, 0, 0};
  int   ldone [3] = '{-100, -100, -100};
  logic pv    [3] = '{1'b0, 1'b0, 1'b0};
  int   pexp  [3] = '{0, 0, 0};

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (pv[k]) begin
        chk($sformatf("pass%0d", k), int'(pass_w[k]), pexp[k]);
        pv[k] = 1'b0;
      end
      if (busy_w[k] && !pbusy[k]) begin
        acc[k] = cyc;
        if (k == 0) pos0 = 0;
        if (k == 2 && cyc - ldone[k] <= 3)
          chk("busy_gap", cyc - ldone[k], 2);
      end else if (k == 0) begin
        pos0 = (pos0 + 1) % 4;
      end
      if (done_w[k]) begin
        ldone[k] = cyc;
        if (sbq.size() == 0) begin
          chk($sformatf("unexpected_done%0d", k), 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("done_id", k, e.id);
          chk($sformatf("lat%0d", k), cyc - acc[k], e.lat);
          chk($sformatf("err%0d", k), int'(err_w[k]), e.err);
          chk($sformatf("fail%0d", k), int'(fail_w[k]), e.fv);
          pv[k]   = 1'b1;
          pexp[k] = e.ps;
        end
      end
      pbusy[k] = busy_w[k];
    end
  end

  task automatic push(input int id, input int er,
                      input int fv, input int ps,
                      input int lat);
    exp_t e;
    e.id = id; e.err = er; e.fv = fv;
    e.ps = ps; e.lat = lat;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input int k, input int lim);
    int n;
    n = 0;
    while (!done_w[k] && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) chk($sformatf("timeout%0d", k), 0, 1);
  endtask

  task automatic go(input int k, input logic [1:0] opv);
    @(negedge clk);
    op = opv;
    start_w[k] = 1'b1;
    @(negedge clk);
    start_w[k] = 1'b0;
    op = ~opv;
    wait_done(k, 200);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int nd;
    start_w = '{1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_w[0]), 0);
    chk("rst_ab", int'({a_w[0], b_w[0]}), 0);
    rst_n = 1'b1;

    push(0, 0, 4'b0000, 1, 16);
    go(0, 2'd0);
    push(0, 2, 4'b1001, 0, 16);
    go(0, 2'd2);
    push(1, 9, 4'b0111, 0, 48);
    go(1, 2'd1);

    push(2, 0, 4'b0000, 1, 8);
    push(2, 0, 4'b0000, 1, 8);
    @(negedge clk);
    op = 2'd3;
    start_w[2] = 1'b1;
    n = 0;
    nd = 0;
    while (nd < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (done_w[2]) nd++;
    end
    start_w[2] = 1'b0;
    if (nd < 2) chk("timeout_b2b", nd, 2);
    repeat (4) @(negedge clk);

    gsel = 1'b1;
    glitch_en = 1'b1;
    push(0, 0, 4'b0000, 1, 16);
    go(0, 2'd1);
    glitch_en = 1'b0;
    gsel = 1'b0;

    @(negedge clk);
    op = 2'd0;
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    n = 0;
    while (!(a_w[0] && !b_w[0]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_combo2", int'({a_w[0], b_w[0]}), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", int'({a_w[0], b_w[0], busy_w[0],
                         done_w[0], pass_w[0]}), 0);
    chk("arst_err", int'(err_w[0]), 0);
    chk("arst_fail", int'(fail_w[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", int'(busy_w[0]), 0);

    push(0, 0, 4'b0000, 1, 16);
    go(0, 2'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
